itype_mc_ctrl: RTL and testbench

//  Multi-cycle control FSM for the I-type datapath: register file, sign-extending immediate unit, ALU, data memory.

---
 rtl/itype_mc_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_itype_mc_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/itype_mc_ctrl.sv
// Multi-cycle control FSM for the I-type datapath (OP-IMM and LOAD), with memory handshake timeouts.
// Optional macro ITYPE_CTRL_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module itype_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  output logic        instr_req,
  input  logic        instr_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic [2:0]  load_f3,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state_dbg,
  output logic [31:0] retire_cnt
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0]  OP_IMM  = 7'b0010011;
  localparam logic [6:0]  OP_LOAD = 7'b0000011;
  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] to_cnt;
  logic [6:0]  opcode_q, f7_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        legal, is_load, fetch_acc;

  // Only opcode/rd/funct3/funct7 matter to control; rs1 and imm go straight to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_in[24:15];

  assign is_load   = (opcode_q == OP_LOAD);
  assign fetch_acc = (state == FETCH) && instr_ack;

  always_comb begin
    legal = 1'b0;
    case (opcode_q)
      OP_IMM: begin
        if (f3_q == 3'b001)      legal = (f7_q == 7'd0);
        else if (f3_q == 3'b101) legal = (f7_q == 7'd0) || (f7_q == 7'b0100000);
        else                     legal = 1'b1;
      end
      OP_LOAD: legal = !(f3_q inside {3'b011, 3'b110, 3'b111});
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      f3_q     <= '0;
      f7_q     <= '0;
      rd_q     <= '0;
    end else if (fetch_acc) begin
      opcode_q <= instr_in[6:0];
      rd_q     <= instr_in[11:7];
      f3_q     <= instr_in[14:12];
      f7_q     <= instr_in[31:25];
    end
  end

  // Wait counter restarts whenever a handshake state is freshly entered.
  always_ff @(posedge clk) begin
    if (rst)
      to_cnt <= '0;
    else if ((state_n != state) && (state_n == FETCH || state_n == MEM))
      to_cnt <= '0;
    else if ((state == FETCH && !instr_ack) || (state == MEM && !dmem_ack))
      to_cnt <= to_cnt + 16'd1;
  end

  always_comb begin
    state_n   = state;
    instr_req = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 4'b0000;
    dmem_req  = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    load_f3   = f3_q;
    state_dbg = state;
    case (state)
      FETCH: begin
        instr_req = 1'b1;
        if (instr_ack) begin
          ir_we   = 1'b1;
          state_n = DECODE;
        end else if (to_cnt == TO_LAST) begin
          bus_err = 1'b1;
          state_n = TRAP;
        end
      end
      DECODE: begin
        if (legal) state_n = EXEC;
        else begin
          illegal = 1'b1;
          state_n = TRAP;
        end
      end
      EXEC:  state_n = is_load ? MEM : WB;
      MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) state_n = WB;
        else if (to_cnt == TO_LAST) begin
          bus_err = 1'b1;
          state_n = TRAP;
        end
      end
      WB: begin
        reg_we  = (rd_q != 5'd0);
        pc_we   = 1'b1;
        state_n = FETCH;
      end
      TRAP: begin
        pc_we   = 1'b1;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
    // ALU controls held steady across EXEC..WB so the datapath sees no glitches mid-instruction.
    if (state == EXEC || state == MEM || state == WB) begin
      alu_src_b = 1'b1;
      alu_op    = is_load ? 4'b0000 : {f7_q[5], f3_q};
      wb_sel    = is_load;
    end
    if (rst) begin
      state_n   = FETCH;
      instr_req = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = 4'b0000;
      dmem_req  = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 1'b0;
      illegal   = 1'b0;
      bus_err   = 1'b0;
      load_f3   = 3'b000;
      state_dbg = 3'b000;
    end
  end

`ifdef ITYPE_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_q;
  always_ff @(posedge clk) begin
    if (rst)              retire_q <= '0;
    else if (state == WB) retire_q <= retire_q + 32'd1;
  end
  assign retire_cnt = rst ? 32'd0 : retire_q;
`else
  assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_itype_mc_ctrl.sv
// Directed cycle-by-cycle bench for itype_mc_ctrl (MEM_TIMEOUT=4 to exercise timeouts quickly).
module tb_itype_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_in = '0;
  logic        instr_ack = 1'b0, dmem_ack = 1'b0;
  logic        instr_req, ir_we, pc_we, alu_src_b, dmem_req, reg_we, wb_sel, illegal, bus_err;
  logic [3:0]  alu_op;
  logic [2:0]  load_f3, state_dbg;
  logic [31:0] retire_cnt;
  int          n_cmp = 0, n_err = 0;

  itype_mc_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_req(instr_req), .instr_ack(instr_ack),
    .ir_we(ir_we), .pc_we(pc_we), .alu_src_b(alu_src_b), .alu_op(alu_op), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .load_f3(load_f3), .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal),
    .bus_err(bus_err), .state_dbg(state_dbg), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

`ifdef ITYPE_CTRL_RETIRE_CNT_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  // {instr_req, ir_we, pc_we, alu_src_b, dmem_req, reg_we, wb_sel, illegal, bus_err}
  logic [8:0] flags;
  assign flags = {instr_req, ir_we, pc_we, alu_src_b, dmem_req, reg_we, wb_sel, illegal, bus_err};

  localparam logic [8:0] F_Z    = 9'b000000000;
  localparam logic [8:0] F_REQ  = 9'b100000000;
  localparam logic [8:0] F_IR   = 9'b110000000;
  localparam logic [8:0] F_EX   = 9'b000100000;
  localparam logic [8:0] F_EXL  = 9'b000100100;
  localparam logic [8:0] F_MEM  = 9'b000110100;
  localparam logic [8:0] F_MTO  = 9'b000110101;
  localparam logic [8:0] F_FTO  = 9'b100000001;
  localparam logic [8:0] F_WBA  = 9'b001101000;
  localparam logic [8:0] F_WB0  = 9'b001100000;
  localparam logic [8:0] F_WBL  = 9'b001101100;
  localparam logic [8:0] F_ILL  = 9'b000000010;
  localparam logic [8:0] F_TRAP = 9'b001000000;

  localparam logic [31:0] ADDI_X1  = 32'h00500093;
  localparam logic [31:0] LW_X2    = 32'h0080A103;
  localparam logic [31:0] SRAI_X3  = 32'h4020D193;
  localparam logic [31:0] SLLI_BAD = 32'h40209193;
  localparam logic [31:0] ADD_R    = 32'h003100B3;
  localparam logic [31:0] LD_BAD   = 32'h0080B103;
  localparam logic [31:0] NOP_X0   = 32'h00000013;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs 1ns later.
  task automatic cyc(input string tag, input logic ia, input logic [31:0] ins, input logic da,
                     input logic r, input logic [2:0] est, input logic [8:0] efl);
    @(negedge clk);
    instr_ack = ia; instr_in = ins; dmem_ack = da; rst = r;
    #1;
    chk({tag, "/st"}, 32'(state_dbg), 32'(est));
    chk({tag, "/fl"}, 32'(flags), 32'(efl));
  endtask

  task automatic run_opimm(input string tag, input logic [31:0] ins, input logic [8:0] wbfl,
                           input logic [3:0] eop);
    cyc({tag, "c0"}, 1'b1, ins, 1'b0, 1'b0, 3'd0, F_IR);
    cyc({tag, "c1"}, 1'b0, ins, 1'b0, 1'b0, 3'd1, F_Z);
    cyc({tag, "c2"}, 1'b0, ins, 1'b0, 1'b0, 3'd2, F_EX);
    chk({tag, "c2/op"}, 32'(alu_op), 32'(eop));
    cyc({tag, "c3"}, 1'b0, ins, 1'b0, 1'b0, 3'd4, wbfl);
    chk({tag, "c3/op"}, 32'(alu_op), 32'(eop));
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] ins);
    cyc({tag, "c0"}, 1'b1, ins, 1'b0, 1'b0, 3'd0, F_IR);
    cyc({tag, "c1"}, 1'b0, ins, 1'b0, 1'b0, 3'd1, F_ILL);
    cyc({tag, "c2"}, 1'b0, ins, 1'b0, 1'b0, 3'd5, F_TRAP);
  endtask

  initial begin
    cyc("rst0", 1'b0, '0, 1'b0, 1'b1, 3'd0, F_Z);
    cyc("rst1", 1'b1, ADDI_X1, 1'b1, 1'b1, 3'd0, F_Z);
    chk("rst1/rc", retire_cnt, 32'd0);
    chk("rst1/f3", 32'(load_f3), 32'd0);

    run_opimm("t1", ADDI_X1, F_WBA, 4'b0000);

    cyc("t2c0", 1'b1, LW_X2, 1'b0, 1'b0, 3'd0, F_IR);
    cyc("t2c1", 1'b0, LW_X2, 1'b0, 1'b0, 3'd1, F_Z);
    cyc("t2c2", 1'b0, LW_X2, 1'b0, 1'b0, 3'd2, F_EXL);
    for (int i = 0; i < 3; i++) cyc("t2wait", 1'b0, LW_X2, 1'b0, 1'b0, 3'd3, F_MEM);
    cyc("t2ack", 1'b0, LW_X2, 1'b1, 1'b0, 3'd3, F_MEM);
    cyc("t2wb", 1'b0, LW_X2, 1'b0, 1'b0, 3'd4, F_WBL);
    chk("t2wb/f3", 32'(load_f3), 32'd2);
    chk("t2wb/op", 32'(alu_op), 32'd0);

    run_opimm("t3a", SRAI_X3, F_WBA, 4'b1101);
    run_illegal("t3b", SLLI_BAD);
    run_illegal("t4", ADD_R);
    run_illegal("ld3", LD_BAD);
    run_opimm("rd0", NOP_X0, F_WB0, 4'b0000);

    // Data-side timeout; a late dmem_ack must not revive the load.
    cyc("t5c0", 1'b1, LW_X2, 1'b0, 1'b0, 3'd0, F_IR);
    chk("t5c0/rc", retire_cnt, RC_EN ? 32'd4 : 32'd0);
    cyc("t5c1", 1'b0, LW_X2, 1'b0, 1'b0, 3'd1, F_Z);
    cyc("t5c2", 1'b0, LW_X2, 1'b0, 1'b0, 3'd2, F_EXL);
    for (int i = 0; i < 3; i++) cyc("t5wait", 1'b0, LW_X2, 1'b0, 1'b0, 3'd3, F_MEM);
    cyc("t5to", 1'b0, LW_X2, 1'b0, 1'b0, 3'd3, F_MTO);
    cyc("t5trap", 1'b0, LW_X2, 1'b1, 1'b0, 3'd5, F_TRAP);
    cyc("t5f", 1'b0, LW_X2, 1'b1, 1'b0, 3'd0, F_REQ);

    // Fetch-side timeout (t5f was wait cycle 1); instr_ack in TRAP is ignored.
    for (int i = 0; i < 2; i++) cyc("ftwait", 1'b0, ADDI_X1, 1'b0, 1'b0, 3'd0, F_REQ);
    cyc("ftto", 1'b0, ADDI_X1, 1'b0, 1'b0, 3'd0, F_FTO);
    cyc("fttrap", 1'b1, ADDI_X1, 1'b0, 1'b0, 3'd5, F_TRAP);
    cyc("ftf", 1'b0, ADDI_X1, 1'b0, 1'b0, 3'd0, F_REQ);

    // Reset in MEM with dmem_ack high.
    cyc("t6c0", 1'b1, LW_X2, 1'b0, 1'b0, 3'd0, F_IR);
    cyc("t6c1", 1'b0, LW_X2, 1'b0, 1'b0, 3'd1, F_Z);
    cyc("t6c2", 1'b0, LW_X2, 1'b0, 1'b0, 3'd2, F_EXL);
    cyc("t6m", 1'b0, LW_X2, 1'b0, 1'b0, 3'd3, F_MEM);
    cyc("t6rst", 1'b0, LW_X2, 1'b1, 1'b1, 3'd0, F_Z);
    chk("t6rst/rc", retire_cnt, 32'd0);
    chk("t6rst/op", 32'(alu_op), 32'd0);
    cyc("t6f", 1'b0, LW_X2, 1'b1, 1'b0, 3'd0, F_REQ);
    chk("t6f/rc", retire_cnt, 32'd0);
    run_opimm("t6a", ADDI_X1, F_WBA, 4'b0000);
    run_opimm("t6b", ADDI_X1, F_WBA, 4'b0000);
    run_opimm("t6c", ADDI_X1, F_WBA, 4'b0000);
    cyc("t6end", 1'b0, ADDI_X1, 1'b0, 1'b0, 3'd0, F_REQ);
    chk("t6end/rc", retire_cnt, RC_EN ? 32'd3 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
